// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // First set request bit, searching upward from last+1 and wrapping 3 -> 0.
  // The previous owner is considered last, so it only wins again when alone.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = last + IDX_W'(i);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
//
// Handshake: a requester holds req[k] high for as long as it wants the
// resource. grant is one-hot while an owner exists; the owner ends its tenure
// either by pulsing done or by dropping its req bit. timeout pulses for one
// cycle when the arbiter itself revoked the grant at the hold limit.
interface rr_arbiter4_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             timeout;

  // Requester side.
  modport master (
    output req, done,
    input  grant, grant_idx, busy, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output grant, grant_idx, busy, timeout
  );
endinterface

// File: rtl/rr_arbiter4_grant_decode.sv
// 2-to-4 one-hot decode of the owner index, forced to zero when disabled.
module grant_decode
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  // Decode the index; all-zero whenever no grant is active.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Every tenure is followed by a one-cycle GAP and an IDLE arbitration cycle,
// so the resource always sees at least one cycle with no owner.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_arbiter4_if.slave       bus,
  output state_t             dbg_state
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t           state_q, state_nx;
  logic [IDX_W-1:0] idx_q, idx_nx;
  logic [IDX_W-1:0] last_q, last_nx;
  logic [7:0]       hold_q, hold_nx;
  logic             timeout_q, timeout_nx;

  logic rel;
  logic at_limit;

  // Owner gives up the resource voluntarily, or the hold limit is hit.
  assign rel      = bus.done || !bus.req[idx_q];
  assign at_limit = (hold_q == HOLD_LIMIT);

  // Next-state and next-register values for the arbitration FSM.
  always_comb begin
    state_nx   = state_q;
    idx_nx     = idx_q;
    last_nx    = last_q;
    hold_nx    = hold_q;
    timeout_nx = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_nx = GRANT;
          idx_nx   = rr_pick(bus.req, last_q);
          hold_nx  = 8'd0;
        end
      end
      GRANT: begin
        hold_nx = hold_q + 8'd1;
        if (rel || at_limit) begin
          state_nx   = GAP;
          last_nx    = idx_q;
          // A voluntary release on the limit cycle is not a timeout.
          timeout_nx = at_limit && !rel;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers; last_q resets to 3 so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nx;
      idx_q     <= idx_nx;
      last_q    <= last_nx;
      hold_q    <= hold_nx;
      timeout_q <= timeout_nx;
    end
  end

  grant_decode u_grant_decode (
    .idx    (idx_q),
    .en     (state_q == GRANT),
    .onehot (bus.grant)
  );

  assign bus.grant_idx = idx_q;
  assign bus.busy      = |bus.grant;
  assign bus.timeout   = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: expected outputs are queued as each step is
// driven and compared once the cycle they describe is visible.
module tb_rr_arbiter4;
  import rr_arb_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: {grant[3:0], grant_idx[1:0], busy, timeout}.
  logic [7:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag);
    logic [7:0] exp;
    logic [7:0] obs;
    obs = {bus.grant, bus.grant_idx, bus.busy, bus.timeout};
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: no expected entry queued, got %b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got grant=%b idx=%0d busy=%b timeout=%b, expected grant=%b idx=%0d busy=%b timeout=%b",
                  tag, obs[7:4], obs[3:2], obs[1], obs[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, compare.
  task automatic step(input logic [3:0] r, input logic d, input logic [3:0] eg,
                      input logic [1:0] ei, input logic et, input string tag);
    bus.req  = r;
    bus.done = d;
    exp_q.push_back({eg, ei, |eg, et});
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Assert reset away from a clock edge, check outputs drop at once, release.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(8'b0000_00_0_0);
    check(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    rst_n    = 1'b0;
    #2;
    exp_q.push_back(8'b0000_00_0_0);
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic two-requester hand-off; requester 0 has first priority.
    step(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b0, "t1_grant0");
    step(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, "t1_gap");
    step(4'b0101, 1'b0, 4'b0000, 2'd0, 1'b0, "t1_idle");
    step(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b0, "t1_grant2");
    step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, "t1_drop_gap");
    step(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, "t1_done_in_idle");

    // All requesting: strict rotation with wrap back to 0.
    do_reset("t2_reset");
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      step(4'b1111, 1'b0, oh,      2'(k % 4), 1'b0, "t2_grant");
      step(4'b1111, 1'b1, 4'b0000, 2'(k % 4), 1'b0, "t2_gap");
      step(4'b1111, 1'b0, 4'b0000, 2'(k % 4), 1'b0, "t2_idle");
    end

    // Hold limit: 15 grant cycles then a one-cycle timeout pulse.
    do_reset("t3_reset");
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "t3_grant");
    for (int k = 0; k < 14; k++)
      step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "t3_hold");
    step(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b1, "t3_timeout");
    step(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, "t3_after");

    // Owner 3 drops its request; pending requester 0 wins via wrap.
    step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0, "t4_grant3");
    step(4'b0001, 1'b0, 4'b0000, 2'd3, 1'b0, "t4_drop_gap");
    step(4'b0001, 1'b0, 4'b0000, 2'd3, 1'b0, "t4_idle");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "t4_wrap_grant0");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "t4_done_gap");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "t4_idle2");

    // done on the limit cycle is a normal release: no timeout.
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "t5_grant");
    for (int k = 0; k < 14; k++)
      step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "t5_hold");
    step(4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, "t5_done_at_limit");
    step(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, "t5_idle");

    // Reset in the middle of a grant.
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "t6_grant0");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "t6_hold");
    do_reset("t6_mid_grant_reset");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "t6_no_gap_pulse");
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "t6_grant3");
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "t6_hold3");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
